// File: rtl/matmul_engine.sv
// Sequenced C = A x B over a word-addressed operand memory: 2*Dim+1 cycles per C element, Dim^2*(2*Dim+1)+1 cycles busy.
// No backpressure: reads return a fixed one cycle after RdEn, and writes are single-cycle strobes that are assumed to always land.
module matmul_engine #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int ADDR_W = 10,
    parameter int DIM_W  = $clog2(N + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DIM_W-1:0]  Dim,
    input  logic [ADDR_W-1:0] BaseA,
    input  logic [ADDR_W-1:0] BaseB,
    input  logic [ADDR_W-1:0] BaseC,
    output logic [ADDR_W-1:0] RdAddrA,
    output logic [ADDR_W-1:0] RdAddrB,
    output logic              RdEn,
    input  logic [DATA_W-1:0] RdDataA,
    input  logic [DATA_W-1:0] RdDataB,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0]  dim;
    logic [DIM_W-1:0]  dim_m1;
    logic [DIM_W-1:0]  dim_sat;
    logic [DIM_W-1:0]  i, j, k;
    logic [ADDR_W-1:0] base_a, base_b, base_c;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] prod;
    logic              last_i, last_j, last_k;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c;

    assign dim_sat = (Dim > DIM_W'(N)) ? DIM_W'(N) : Dim;
    assign dim_m1  = dim - DIM_W'(1);
    assign last_i  = (i == dim_m1);
    assign last_j  = (j == dim_m1);
    assign last_k  = (k == dim_m1);

    // Low DATA_W bits of a product are the same for signed and unsigned operands.
    assign prod = RdDataA * RdDataB;

    assign addr_a = base_a + ADDR_W'(i) * ADDR_W'(dim) + ADDR_W'(k);
    assign addr_b = base_b + ADDR_W'(k) * ADDR_W'(dim) + ADDR_W'(j);
    assign addr_c = base_c + ADDR_W'(i) * ADDR_W'(dim) + ADDR_W'(j);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = (Dim == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_ACC;
            S_ACC:   state_nxt = last_k ? S_WRITE : S_ISSUE;
            S_WRITE: state_nxt = (last_i && last_j) ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= S_IDLE;
            dim    <= '0;
            base_a <= '0;
            base_b <= '0;
            base_c <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        dim    <= dim_sat;
                        base_a <= BaseA;
                        base_b <= BaseB;
                        base_c <= BaseC;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        acc    <= '0;
                    end
                end
                S_ACC: begin
                    acc <= acc + prod;
                    if (!last_k) begin
                        k <= k + DIM_W'(1);
                    end
                end
                S_WRITE: begin
                    acc <= '0;
                    k   <= '0;
                    if (last_j) begin
                        j <= '0;
                        i <= i + DIM_W'(1);
                    end else begin
                        j <= j + DIM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != S_IDLE);
    assign RdEn = (state == S_ISSUE);
    assign WrEn = (state == S_WRITE);
    assign Done = (state == S_DONE);

    // Address/data buses are held at zero outside their strobe so idle and reset values are clean.
    assign RdAddrA = RdEn ? addr_a : '0;
    assign RdAddrB = RdEn ? addr_b : '0;
    assign WrAddr  = WrEn ? addr_c : '0;
    assign WrData  = WrEn ? acc    : '0;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: behavioural operand memory, write/cycle monitor, hand-computed expectations.
module tb_matmul_engine;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Dim = '0;
    logic [9:0]  BaseA = '0, BaseB = '0, BaseC = '0;
    logic [9:0]  RdAddrA, RdAddrB, WrAddr;
    logic        RdEn, WrEn, Busy, Done;
    logic [31:0] RdDataA = '0, RdDataB = '0, WrData;

    matmul_engine #(.DATA_W(32), .N(4), .ADDR_W(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Dim(Dim),
        .BaseA(BaseA), .BaseB(BaseB), .BaseC(BaseC),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdEn(RdEn),
        .RdDataA(RdDataA), .RdDataB(RdDataB),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [0:1023];

    always @(posedge Clk) begin
        if (RdEn) begin
            RdDataA <= mem[RdAddrA];
            RdDataB <= mem[RdAddrB];
        end
    end

    int          busy_cnt, rd_cnt, done_cnt, consec_cnt, done_nobusy;
    logic        prev_wr;
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge Clk) begin
        if (Busy) busy_cnt++;
        if (RdEn) rd_cnt++;
        if (Done) done_cnt++;
        if (Done && !Busy) done_nobusy++;
        if (WrEn && prev_wr) consec_cnt++;
        if (WrEn) begin
            wa_q.push_back(WrAddr);
            wd_q.push_back(WrData);
        end
        prev_wr = WrEn;
    end

    int total  = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        busy_cnt = 0; rd_cnt = 0; done_cnt = 0; consec_cnt = 0; done_nobusy = 0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic start_op(input logic [2:0] d, input logic [9:0] ba, input logic [9:0] bb, input logic [9:0] bc);
        @(negedge Clk);
        clear_mon();
        Dim = d; BaseA = ba; BaseB = bb; BaseC = bc;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Waits for Done (bounded); optionally disturbs Start/Dim/bases mid-operation.
    task automatic wait_done(input string tag, input bit disturb);
        bit seen = 0;
        for (int c = 0; c < 400; c++) begin
            if (disturb && c == 4) begin
                Start = 1'b1; Dim = 3'd1; BaseA = 10'd50; BaseB = 10'd60; BaseC = 10'd70;
            end
            if (disturb && c == 9) Start = 1'b0;
            if (Done) begin
                seen = 1;
                break;
            end
            @(negedge Clk);
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge Clk);
    endtask

    function automatic logic [31:0] wd_at(input int n);
        return (n < wd_q.size()) ? wd_q[n] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [9:0] wa_at(input int n);
        return (n < wa_q.size()) ? wa_q[n] : 10'hxxx;
    endfunction

    task automatic check_dim2(input string tag, input logic [9:0] bc);
        logic [31:0] exp_c [4];
        exp_c[0] = 32'd19; exp_c[1] = 32'd22; exp_c[2] = 32'd43; exp_c[3] = 32'd50;
        chk({tag, "_wr_count"}, 64'(wa_q.size()), 64'd4);
        for (int n = 0; n < 4; n++) begin
            chk({tag, "_wr_addr"}, 64'(wa_at(n)), 64'(bc + 10'(n)));
            chk({tag, "_wr_data"}, 64'(wd_at(n)), 64'(exp_c[n]));
        end
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd21);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_rd_count"}, 64'(rd_cnt), 64'd8);
        chk({tag, "_consec_wr"}, 64'(consec_cnt), 64'd0);
    endtask

    task automatic check_dim4(input string tag, input logic [9:0] bc);
        chk({tag, "_wr_count"}, 64'(wa_q.size()), 64'd16);
        for (int n = 0; n < 16; n++) begin
            chk({tag, "_wr_addr"}, 64'(wa_at(n)), 64'(bc + 10'(n)));
            chk({tag, "_wr_data"}, 64'(wd_at(n)), 64'(n));
        end
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd145);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_rd_count"}, 64'(rd_cnt), 64'd64);
        chk({tag, "_consec_wr"}, 64'(consec_cnt), 64'd0);
        chk({tag, "_done_nobusy"}, 64'(done_nobusy), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},    64'(Busy),    64'd0);
        chk({tag, "_done"},    64'(Done),    64'd0);
        chk({tag, "_rden"},    64'(RdEn),    64'd0);
        chk({tag, "_wren"},    64'(WrEn),    64'd0);
        chk({tag, "_rdaddra"}, 64'(RdAddrA), 64'd0);
        chk({tag, "_rdaddrb"}, 64'(RdAddrB), 64'd0);
        chk({tag, "_wraddr"},  64'(WrAddr),  64'd0);
        chk({tag, "_wrdata"},  64'(WrData),  64'd0);
    endtask

    initial begin
        prev_wr = 1'b0;
        clear_mon();
        for (int a = 0; a < 1024; a++) mem[a] = '0;
        // A = [[1,2],[3,4]] at 0, B = [[5,6],[7,8]] at 4
        for (int a = 0; a < 8; a++) mem[a] = 32'(a + 1);
        mem[20] = 32'h7FFFFFFF; mem[21] = 32'd2;
        mem[30] = 32'hFFFFFFFD; mem[31] = 32'd4;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mem[100 + r * 4 + c] = (r == c) ? 32'd1 : 32'd0;
        for (int a = 0; a < 16; a++) mem[200 + a] = 32'(a);

        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check_idle_outputs("reset");
        Reset = 1'b1;
        @(negedge Clk);

        start_op(3'd2, 10'd0, 10'd4, 10'd8);
        wait_done("dim2", 0);
        check_dim2("dim2", 10'd8);

        start_op(3'd1, 10'd20, 10'd21, 10'd22);
        wait_done("dim1_ovf", 0);
        chk("dim1_ovf_data", 64'(wd_at(0)), 64'h0000_0000_FFFF_FFFE);
        chk("dim1_ovf_addr", 64'(wa_at(0)), 64'd22);
        chk("dim1_ovf_busy", 64'(busy_cnt), 64'd4);

        start_op(3'd1, 10'd30, 10'd31, 10'd32);
        wait_done("dim1_neg", 0);
        chk("dim1_neg_data", 64'(wd_at(0)), 64'h0000_0000_FFFF_FFF4);
        chk("dim1_neg_busy", 64'(busy_cnt), 64'd4);
        chk("dim1_neg_wrcnt", 64'(wa_q.size()), 64'd1);

        start_op(3'd4, 10'd100, 10'd200, 10'd300);
        wait_done("dim4", 0);
        check_dim4("dim4", 10'd300);

        start_op(3'd0, 10'd0, 10'd4, 10'd8);
        wait_done("dim0", 0);
        chk("dim0_busy", 64'(busy_cnt), 64'd1);
        chk("dim0_done", 64'(done_cnt), 64'd1);
        chk("dim0_rd", 64'(rd_cnt), 64'd0);
        chk("dim0_wr", 64'(wa_q.size()), 64'd0);
        chk("dim0_done_nobusy", 64'(done_nobusy), 64'd0);

        start_op(3'd7, 10'd100, 10'd200, 10'd400);
        wait_done("dim7", 0);
        check_dim4("dim7", 10'd400);

        start_op(3'd2, 10'd0, 10'd4, 10'd8);
        wait_done("disturb", 1);
        check_dim2("disturb", 10'd8);

        start_op(3'd2, 10'd0, 10'd4, 10'd8);
        for (int c = 0; c < 100 && wa_q.size() < 2; c++) @(negedge Clk);
        chk("rst_mid_two_writes", 64'(wa_q.size()), 64'd2);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_idle_outputs("rst_mid");
        Reset = 1'b1;
        repeat (30) @(negedge Clk);
        chk("rst_mid_no_more_wr", 64'(wa_q.size()), 64'd2);
        chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
        chk("rst_mid_busy_low", 64'(Busy), 64'd0);

        start_op(3'd2, 10'd0, 10'd4, 10'd8);
        wait_done("after_rst", 0);
        check_dim2("after_rst", 10'd8);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
